// File: rtl/mega_regs_mp_if.sv
// Bundles all read, write and status signals of the AVR core multi-port register file.
// Latency: the interface adds none; read latency is set by the register file's REGISTERED parameter.
// Backpressure: none. Accesses are accepted every cycle, and writes are silently dropped until ready is high.
// Ports: rs1a/rs1m/rs1 and rs2a/rs2m/rs2 are the read ports (address, word mode, data).
//        rda/rd/rdw/rdm is byte-or-word write port A; rpa/rp/rpw is word write port B; ready is the clear-done status.
interface mega_regs_mp_if #(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 32
);
  localparam int AW = $clog2(REG_CNT);

  logic [AW-1:0]       rs1a;
  logic                rs1m;
  logic [2*DATA_W-1:0] rs1;
  logic [AW-1:0]       rs2a;
  logic                rs2m;
  logic [2*DATA_W-1:0] rs2;
  logic [AW-1:0]       rda;
  logic [2*DATA_W-1:0] rd;
  logic                rdw;
  logic                rdm;
  logic [AW-2:0]       rpa;
  logic [2*DATA_W-1:0] rp;
  logic                rpw;
  logic                ready;

  modport master (
    output rs1a, rs1m, rs2a, rs2m, rda, rd, rdw, rdm, rpa, rp, rpw,
    input  rs1, rs2, ready
  );

  modport slave (
    input  rs1a, rs1m, rs2a, rs2m, rda, rd, rdw, rdm, rpa, rp, rpw,
    output rs1, rs2, ready
  );
endinterface

// File: rtl/mega_regs_mp.sv
// Purpose: AVR register file with two byte/word read ports, write port A (byte or word) and write port B (word, pointer writeback).
// Latency: reads take 0 cycles when REGISTERED=0 and 1 cycle when REGISTERED=1; writes commit on the rising edge of clk.
// Backpressure: none. While the post-reset clear sweep runs, writes are dropped and reads return 0; ready reports the end of the sweep.
// Ports: clk and rst (asynchronous, active high) are plain ports; every other signal is carried in bus (mega_regs_mp_if.slave).
module mega_regs_mp #(
  parameter int DATA_W     = 8,
  parameter int REG_CNT    = 32,
  parameter int REGISTERED = 0,
  parameter int BYPASS     = 1
) (
  input  logic           clk,
  input  logic           rst,
  mega_regs_mp_if.slave  bus
);
  localparam int AW    = $clog2(REG_CNT);
  localparam int PW    = AW - 1;
  localparam int PAIRS = REG_CNT / 2;
  localparam logic [PW-1:0] LAST = PW'(PAIRS - 1);

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;

  state_t        state;
  logic [PW-1:0] cnt;
  logic          ready_q;
  logic          run;

  logic [DATA_W-1:0] lo_q  [PAIRS];
  logic [DATA_W-1:0] hi_q  [PAIRS];
  logic [DATA_W-1:0] lo_nx [PAIRS];
  logic [DATA_W-1:0] hi_nx [PAIRS];
  logic              lo_we [PAIRS];
  logic              hi_we [PAIRS];
  // Read view: the stored value, or the incoming write data when bypass is enabled.
  logic [DATA_W-1:0] lo_v  [PAIRS];
  logic [DATA_W-1:0] hi_v  [PAIRS];

  assign run       = (state == ST_RUN);
  assign bus.ready = ready_q;

  // Merge the two write ports for each byte. Port A overrides port B byte by byte,
  // so port B still writes any byte of its pair that port A does not touch.
  always_comb begin
    logic a_lo, a_hi, b_hit;
    a_lo  = 1'b0;
    a_hi  = 1'b0;
    b_hit = 1'b0;
    for (int i = 0; i < PAIRS; i++) begin
      b_hit    = bus.rpw && (bus.rpa == PW'(i));
      a_lo     = bus.rdw && (bus.rda[AW-1:1] == PW'(i)) && (bus.rdm || !bus.rda[0]);
      a_hi     = bus.rdw && (bus.rda[AW-1:1] == PW'(i)) && (bus.rdm || bus.rda[0]);
      lo_we[i] = run && (a_lo || b_hit);
      hi_we[i] = run && (a_hi || b_hit);
      lo_nx[i] = a_lo ? bus.rd[DATA_W-1:0] : bus.rp[DATA_W-1:0];
      // A byte write to the odd register takes its data from the low byte of rd.
      hi_nx[i] = a_hi ? (bus.rdm ? bus.rd[2*DATA_W-1:DATA_W] : bus.rd[DATA_W-1:0])
                      : bus.rp[2*DATA_W-1:DATA_W];
      lo_v[i]  = ((BYPASS != 0) && lo_we[i]) ? lo_nx[i] : lo_q[i];
      hi_v[i]  = ((BYPASS != 0) && hi_we[i]) ? hi_nx[i] : hi_q[i];
    end
  end

  // Sequencer: after reset, sweep one pair per cycle to zero it, then enter RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RESET;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_CLEAR;
          cnt   <= '0;
        end
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        default: begin
          state   <= ST_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The array has no reset of its own; the sweep above is what clears it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PAIRS; i++) begin
      if (state == ST_CLEAR && cnt == PW'(i)) begin
        lo_q[i] <= '0;
        hi_q[i] <= '0;
      end else begin
        if (lo_we[i]) lo_q[i] <= lo_nx[i];
        if (hi_we[i]) hi_q[i] <= hi_nx[i];
      end
    end
  end

  function automatic logic [2*DATA_W-1:0] rsel(input logic m, input logic a0,
                                               input logic [DATA_W-1:0] l,
                                               input logic [DATA_W-1:0] h);
    if (m)  return {h, l};
    if (a0) return {{DATA_W{1'b0}}, h};
    return {{DATA_W{1'b0}}, l};
  endfunction

  if (REGISTERED != 0) begin : g_reg
    // Capture the pair bytes together with mode and address bit 0, so the
    // output decode always matches the data that was captured.
    logic [DATA_W-1:0] l1, h1, l2, h2;
    logic              m1, a1, m2, a2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst || !run) begin
        {l1, h1, m1, a1} <= '0;
        {l2, h2, m2, a2} <= '0;
      end else begin
        l1 <= lo_v[bus.rs1a[AW-1:1]];
        h1 <= hi_v[bus.rs1a[AW-1:1]];
        m1 <= bus.rs1m;
        a1 <= bus.rs1a[0];
        l2 <= lo_v[bus.rs2a[AW-1:1]];
        h2 <= hi_v[bus.rs2a[AW-1:1]];
        m2 <= bus.rs2m;
        a2 <= bus.rs2a[0];
      end
    end
    assign bus.rs1 = run ? rsel(m1, a1, l1, h1) : '0;
    assign bus.rs2 = run ? rsel(m2, a2, l2, h2) : '0;
  end else begin : g_comb
    assign bus.rs1 = run ? rsel(bus.rs1m, bus.rs1a[0], lo_v[bus.rs1a[AW-1:1]], hi_v[bus.rs1a[AW-1:1]]) : '0;
    assign bus.rs2 = run ? rsel(bus.rs2m, bus.rs2a[0], lo_v[bus.rs2a[AW-1:1]], hi_v[bus.rs2a[AW-1:1]]) : '0;
  end
endmodule

// File: tb/tb_mega_regs_mp.sv
module tb_mega_regs_mp;
  localparam int DW = 8;
  localparam int RC = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  rs1a = '0, rs2a = '0, rda = '0;
  logic        rs1m = 1'b0, rs2m = 1'b0, rdw = 1'b0, rdm = 1'b0, rpw = 1'b0;
  logic [3:0]  rpa = '0;
  logic [15:0] rd = '0, rp = '0;

  int vectors = 0;
  int errors  = 0;

  // Reference memory: byte n lives at bits [8n +: 8], so a pair reads as one 16-bit word.
  logic [255:0] mem = '0;

  mega_regs_mp_if #(.DATA_W(DW), .REG_CNT(RC)) if_b1 ();
  mega_regs_mp_if #(.DATA_W(DW), .REG_CNT(RC)) if_b0 ();
  mega_regs_mp_if #(.DATA_W(DW), .REG_CNT(RC)) if_rg ();

  assign {if_b1.rs1a, if_b1.rs1m, if_b1.rs2a, if_b1.rs2m, if_b1.rda, if_b1.rd, if_b1.rdw, if_b1.rdm, if_b1.rpa, if_b1.rp, if_b1.rpw} = {rs1a, rs1m, rs2a, rs2m, rda, rd, rdw, rdm, rpa, rp, rpw};
  assign {if_b0.rs1a, if_b0.rs1m, if_b0.rs2a, if_b0.rs2m, if_b0.rda, if_b0.rd, if_b0.rdw, if_b0.rdm, if_b0.rpa, if_b0.rp, if_b0.rpw} = {rs1a, rs1m, rs2a, rs2m, rda, rd, rdw, rdm, rpa, rp, rpw};
  assign {if_rg.rs1a, if_rg.rs1m, if_rg.rs2a, if_rg.rs2m, if_rg.rda, if_rg.rd, if_rg.rdw, if_rg.rdm, if_rg.rpa, if_rg.rp, if_rg.rpw} = {rs1a, rs1m, rs2a, rs2m, rda, rd, rdw, rdm, rpa, rp, rpw};

  mega_regs_mp #(.DATA_W(DW), .REG_CNT(RC), .REGISTERED(0), .BYPASS(1)) dut_b1 (.clk(clk), .rst(rst), .bus(if_b1));
  mega_regs_mp #(.DATA_W(DW), .REG_CNT(RC), .REGISTERED(0), .BYPASS(0)) dut_b0 (.clk(clk), .rst(rst), .bus(if_b0));
  mega_regs_mp #(.DATA_W(DW), .REG_CNT(RC), .REGISTERED(1), .BYPASS(1)) dut_rg (.clk(clk), .rst(rst), .bus(if_rg));

  // The write rules applied in order: port B writes its pair, then port A
  // overwrites whatever bytes it targets.
  function automatic logic [255:0] apply_wr(input logic [255:0] m);
    logic [255:0] r;
    r = m;
    if (rpw) r[16*int'(rpa) +: 16] = rp;
    if (rdw) begin
      if (rdm) r[16*int'(rda[4:1]) +: 16] = rd;
      else     r[8*int'(rda) +: 8] = rd[7:0];
    end
    return r;
  endfunction

  function automatic logic [15:0] mread(input logic [255:0] m, input logic md, input logic [4:0] a);
    if (md) return m[16*int'(a[4:1]) +: 16];
    return {8'h00, m[8*int'(a) +: 8]};
  endfunction

  // Advance one edge in RUN, committing the current writes to the model first.
  task automatic tick();
    mem = apply_wr(mem);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rs1m = 1'b1; rs2m = 1'b0; rs1a = 5'd6; rs2a = 5'd9;
    #1;
    vectors++;
    if (if_b1.ready !== 1'b0 || if_b1.rs1 !== 16'h0 || if_rg.rs1 !== 16'h0 || if_b0.rs2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b rs1=%h rs1_reg=%h rs2=%h, required ready=0 and data 0000", if_b1.ready, if_b1.rs1, if_rg.rs1, if_b0.rs2);
    end
    rst = 1'b0;
    rdw = 1'b1; rdm = 1'b1; rda = 5'd4; rd = 16'hFFFF;
    rpw = 1'b1; rpa = 4'd7; rp = 16'hAAAA;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (if_b1.ready !== (e == 17) || if_rg.ready !== (e == 17)) begin
        errors++;
        $display("FAIL clear_ready edge %0d: ready=%b, required %b", e, if_b1.ready, (e == 17));
      end
      if (e < 17) begin
        vectors++;
        if (if_b1.rs1 !== 16'h0 || if_b0.rs1 !== 16'h0 || if_rg.rs1 !== 16'h0) begin
          errors++;
          $display("FAIL clear_read edge %0d: rs1=%h/%h/%h, required 0000", e, if_b1.rs1, if_b0.rs1, if_rg.rs1);
        end
      end
    end
    rdw = 1'b0; rpw = 1'b0;
    mem = '0;
    for (int b = 0; b < RC; b++) begin
      rs1a = 5'(b); rs1m = 1'b0;
      #1;
      vectors++;
      if (if_b1.rs1 !== 16'h0 || if_b0.rs1 !== 16'h0) begin
        errors++;
        $display("FAIL cleared_byte r%0d: got %h/%h, required 0000", b, if_b1.rs1, if_b0.rs1);
      end
    end
  endtask

  task automatic test_mid_clear();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (if_b1.ready !== 1'b0) begin
      errors++;
      $display("FAIL midclear_early: ready=%b, required 0", if_b1.ready);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (if_b1.ready !== 1'b0) begin
      errors++;
      $display("FAIL midclear_pulse: ready=%b, required 0", if_b1.ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (if_b1.ready !== (e == 17)) begin
        errors++;
        $display("FAIL midclear_ready edge %0d: ready=%b, required %b", e, if_b1.ready, (e == 17));
      end
    end
    mem = '0;
  endtask

  task automatic test_mapping();
    rdw = 1'b1; rdm = 1'b0; rda = 5'd17; rd = 16'h77A5;
    tick();
    rdw = 1'b0; rs1a = 5'd17; rs1m = 1'b0;
    #2;
    vectors++;
    if (if_b1.rs1 !== 16'h00A5 || if_b0.rs1 !== 16'h00A5) begin
      errors++;
      $display("FAIL byte_r17: got %h/%h, required 00a5", if_b1.rs1, if_b0.rs1);
    end
    rdw = 1'b1; rdm = 1'b1; rda = 5'd30; rd = 16'h1234;
    tick();
    rdw = 1'b0; rs2a = 5'd30; rs2m = 1'b1;
    #2;
    vectors++;
    if (if_b1.rs2 !== 16'h1234) begin
      errors++;
      $display("FAIL word_p15: got %h, required 1234", if_b1.rs2);
    end
    rs2a = 5'd31; rs2m = 1'b0;
    #2;
    vectors++;
    if (if_b1.rs2 !== 16'h0012) begin
      errors++;
      $display("FAIL byte_r31: got %h, required 0012", if_b1.rs2);
    end
    // Word write with address bit 0 set still targets the whole pair.
    rdw = 1'b1; rdm = 1'b1; rda = 5'd21; rd = 16'hBEAD;
    tick();
    rdw = 1'b0; rs1a = 5'd21; rs1m = 1'b1;
    #2;
    vectors++;
    if (if_b1.rs1 !== 16'hBEAD) begin
      errors++;
      $display("FAIL word_odd_addr: got %h, required bead", if_b1.rs1);
    end
  endtask

  task automatic test_conflict();
    rpw = 1'b1; rpa = 4'd13; rp = 16'hBEEF;
    rdw = 1'b1; rdm = 1'b0; rda = 5'd27; rd = 16'h0055;
    tick();
    rpw = 1'b0; rdw = 1'b0;
    rs1a = 5'd26; rs1m = 1'b0; rs2a = 5'd27; rs2m = 1'b0;
    #2;
    vectors++;
    if (if_b1.rs1 !== 16'h00EF || if_b1.rs2 !== 16'h0055) begin
      errors++;
      $display("FAIL conflict_hbyte: r26=%h r27=%h, required 00ef 0055", if_b1.rs1, if_b1.rs2);
    end
    rpw = 1'b1; rpa = 4'd13; rp = 16'h2222;
    rdw = 1'b1; rdm = 1'b1; rda = 5'd26; rd = 16'h1111;
    tick();
    rpw = 1'b0; rdw = 1'b0; rs1m = 1'b1;
    #2;
    vectors++;
    if (if_b1.rs1 !== 16'h1111) begin
      errors++;
      $display("FAIL conflict_word: got %h, required 1111", if_b1.rs1);
    end
    rpw = 1'b1; rpa = 4'd13; rp = 16'h3344;
    rdw = 1'b1; rdm = 1'b0; rda = 5'd26; rd = 16'h0066;
    tick();
    rpw = 1'b0; rdw = 1'b0;
    #2;
    vectors++;
    if (if_b1.rs1 !== 16'h3366) begin
      errors++;
      $display("FAIL conflict_lbyte: got %h, required 3366", if_b1.rs1);
    end
  endtask

  task automatic test_bypass();
    rdw = 1'b1; rdm = 1'b0; rda = 5'd5; rd = 16'h00C3;
    tick();
    rd = 16'h003C; rs1a = 5'd5; rs1m = 1'b0;
    #2;
    vectors++;
    if (if_b1.rs1 !== 16'h003C) begin
      errors++;
      $display("FAIL bypass_on: got %h, required 003c", if_b1.rs1);
    end
    vectors++;
    if (if_b0.rs1 !== 16'h00C3) begin
      errors++;
      $display("FAIL bypass_off_pre: got %h, required 00c3", if_b0.rs1);
    end
    tick();
    rdw = 1'b0;
    #1;
    vectors++;
    if (if_b0.rs1 !== 16'h003C) begin
      errors++;
      $display("FAIL bypass_off_post: got %h, required 003c", if_b0.rs1);
    end
    // Per-byte bypass of the merged data: B writes pair 2, A overrides H only.
    rpw = 1'b1; rpa = 4'd2; rp = 16'h9A9B;
    rdw = 1'b1; rdm = 1'b0; rda = 5'd5; rd = 16'h0077;
    rs2a = 5'd4; rs2m = 1'b1;
    #2;
    vectors++;
    if (if_b1.rs2 !== 16'h779B) begin
      errors++;
      $display("FAIL bypass_merge: got %h, required 779b", if_b1.rs2);
    end
    tick();
    rpw = 1'b0; rdw = 1'b0;
  endtask

  task automatic test_registered();
    rs1a = 5'd24; rs1m = 1'b1;
    rpw = 1'b1; rpa = 4'd12; rp = 16'hCAFE;
    tick();
    rpw = 1'b0;
    vectors++;
    if (if_rg.rs1 !== 16'hCAFE) begin
      errors++;
      $display("FAIL reg_capture: got %h, required cafe", if_rg.rs1);
    end
    rs1a = 5'd3; rs1m = 1'b0;
    #2;
    vectors++;
    if (if_rg.rs1 !== 16'hCAFE) begin
      errors++;
      $display("FAIL reg_hold: got %h, required cafe", if_rg.rs1);
    end
    tick();
    vectors++;
    if (if_rg.rs1 !== mread(mem, 1'b0, 5'd3)) begin
      errors++;
      $display("FAIL reg_next: got %h, required %h", if_rg.rs1, mread(mem, 1'b0, 5'd3));
    end
  endtask

  task automatic test_random();
    logic [255:0] post;
    for (int n = 0; n < 400; n++) begin
      rs1a = 5'($urandom); rs1m = 1'($urandom);
      rs2a = 5'($urandom); rs2m = 1'($urandom);
      rda  = 5'($urandom); rd = 16'($urandom); rdw = 1'($urandom); rdm = 1'($urandom);
      rpa  = ($urandom_range(0, 2) == 0) ? rda[4:1] : 4'($urandom);
      rp   = 16'($urandom); rpw = 1'($urandom);
      if ($urandom_range(0, 1) == 1) rs1a = rda;
      #2;
      post = apply_wr(mem);
      vectors++;
      if (if_b1.rs1 !== mread(post, rs1m, rs1a) || if_b1.rs2 !== mread(post, rs2m, rs2a)) begin
        errors++;
        $display("FAIL rand_bypass #%0d: rs1=%h rs2=%h, required %h %h", n, if_b1.rs1, if_b1.rs2, mread(post, rs1m, rs1a), mread(post, rs2m, rs2a));
      end
      vectors++;
      if (if_b0.rs1 !== mread(mem, rs1m, rs1a) || if_b0.rs2 !== mread(mem, rs2m, rs2a)) begin
        errors++;
        $display("FAIL rand_nobypass #%0d: rs1=%h rs2=%h, required %h %h", n, if_b0.rs1, if_b0.rs2, mread(mem, rs1m, rs1a), mread(mem, rs2m, rs2a));
      end
      tick();
      vectors++;
      if (if_rg.rs1 !== mread(mem, rs1m, rs1a) || if_rg.rs2 !== mread(mem, rs2m, rs2a)) begin
        errors++;
        $display("FAIL rand_registered #%0d: rs1=%h rs2=%h, required %h %h", n, if_rg.rs1, if_rg.rs2, mread(mem, rs1m, rs1a), mread(mem, rs2m, rs2a));
      end
      vectors++;
      if (if_b1.ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_ready #%0d: ready=%b, required 1", n, if_b1.ready);
      end
    end
    rdw = 1'b0; rpw = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mid_clear();
    test_mapping();
    test_conflict();
    test_bypass();
    test_registered();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
